flag_register_unit: RTL and testbench

- Architectural NZCV status register that sits directly upstream of the condition checker in the execute interface.
- Commits ALU flag results gated by the current instruction's condition-met result, with per-flag write mask and direct MSR-style writes.
- Keeps a small LIFO shadow stack of flags for interrupt entry and return.
- Drives the N/Z/C/V inputs of the condition checker every cycle.

---
 rtl/flag_register_unit_pkg.sv | 24 ++
 rtl/flag_register_unit_if.sv | 47 ++++
 rtl/flag_register_unit_shadow_stack.sv | 68 ++++++
 rtl/flag_register_unit.sv | 122 ++++++++++++
 tb/tb_flag_register_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/flag_register_unit_pkg.sv
// Shared types and constants for the NZCV flag register unit and its shadow stack.
package flag_register_unit_pkg;

   typedef logic [3:0] flags_t;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   localparam flags_t FLAG_RESET_DEFAULT = 4'b0000;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_OVERFLOW  = 2'd1,
      ERR_UNDERFLOW = 2'd2,
      ERR_ILLEGAL   = 2'd3
   } err_cause_t;

   function automatic int unsigned depth_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/flag_register_unit_if.sv
// Execute-stage bus between the flag register unit and its driver / condition checker.
interface flag_register_unit_if
   import flag_register_unit_pkg::*;
#(
   parameter int unsigned SHADOW_DEPTH = 2
);
   logic                               controlInStall;
   logic                               controlInFlush;
   logic                               controlInSetFlags;
   logic                               controlInCondMet;
   flags_t                             dataInMask;
   logic                               dataInN;
   logic                               dataInZ;
   logic                               dataInC;
   logic                               dataInV;
   logic                               controlInMsrWrite;
   flags_t                             dataInMsr;
   logic                               controlInIrqSave;
   logic                               controlInIrqRestore;
   logic                               controlInErrClr;
   logic                               dataOutN;
   logic                               dataOutZ;
   logic                               dataOutC;
   logic                               dataOutV;
   logic [depth_w(SHADOW_DEPTH)-1:0]   dataOutDepth;
   logic                               dataOutStackFull;
   logic                               dataOutStackEmpty;
   logic                               dataOutStackErr;

   modport master (
      output controlInStall, controlInFlush, controlInSetFlags, controlInCondMet,
             dataInMask, dataInN, dataInZ, dataInC, dataInV,
             controlInMsrWrite, dataInMsr, controlInIrqSave, controlInIrqRestore,
             controlInErrClr,
      input  dataOutN, dataOutZ, dataOutC, dataOutV, dataOutDepth,
             dataOutStackFull, dataOutStackEmpty, dataOutStackErr
   );

   modport slave (
      input  controlInStall, controlInFlush, controlInSetFlags, controlInCondMet,
             dataInMask, dataInN, dataInZ, dataInC, dataInV,
             controlInMsrWrite, dataInMsr, controlInIrqSave, controlInIrqRestore,
             controlInErrClr,
      output dataOutN, dataOutZ, dataOutC, dataOutV, dataOutDepth,
             dataOutStackFull, dataOutStackEmpty, dataOutStackErr
   );
endinterface

// File: rtl/flag_register_unit_shadow_stack.sv
// LIFO of saved flag vectors for interrupt entry/return; refuses push when full and pop when empty.
module flag_shadow_stack
   import flag_register_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_push,
   input  logic                        i_pop,
   input  flags_t                      i_data,
   output flags_t                      o_top_c,
   output logic [depth_w(DEPTH)-1:0]   o_depth,
   output logic                        o_full,
   output logic                        o_empty,
   output logic                        o_overflow_c,
   output logic                        o_underflow_c
);
   localparam int unsigned DEPTH_W = depth_w(DEPTH);
   localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned MEM_N   = 1 << IDX_W;

   flags_t               r_mem [MEM_N];
   logic [DEPTH_W-1:0]   r_depth;
   logic [DEPTH_W-1:0]   w_depth_nxt;
   logic                 r_full;
   logic                 r_empty;
   logic                 w_do_push;
   logic                 w_do_pop;

   assign w_do_push     = i_push & ~r_full;
   assign w_do_pop      = i_pop & ~i_push & ~r_empty;
   assign o_overflow_c  = i_push & r_full;
   assign o_underflow_c = i_pop & ~i_push & r_empty;

   always_comb begin
      w_depth_nxt = r_depth;
      if (w_do_push)
         w_depth_nxt = r_depth + DEPTH_W'(1);
      else if (w_do_pop)
         w_depth_nxt = r_depth - DEPTH_W'(1);
   end

   // Full/empty are registered alongside depth so status never glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_depth <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_depth <= w_depth_nxt;
         r_full  <= (w_depth_nxt == DEPTH_W'(DEPTH));
         r_empty <= (w_depth_nxt == '0);
      end
   end

   // Slot contents are don't-care after reset, so the storage carries no reset.
   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[IDX_W'(r_depth)] <= i_data;
   end

   assign o_top_c = r_mem[IDX_W'(r_depth - DEPTH_W'(1))];
   assign o_depth = r_depth;
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/flag_register_unit.sv
// Architectural NZCV register: restore > MSR > masked ALU commit, with interrupt shadow stack.
// Define FLAG_BYPASS_EN to drive the flag outputs from the combinational next-flag value.
module flag_register_unit
   import flag_register_unit_pkg::*;
#(
   parameter int unsigned SHADOW_DEPTH = 2,
   parameter flags_t      FLAG_RESET   = FLAG_RESET_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   flag_register_unit_if.slave  bus
);
   localparam int unsigned DEPTH_W = depth_w(SHADOW_DEPTH);

   flags_t               r_flags;
   flags_t               w_flags_nxt;
   flags_t               w_alu;
   flags_t               w_top;
   logic                 w_active;
   logic                 w_save_req;
   logic                 w_rest_req;
   logic                 w_illegal;
   logic                 w_pop_ok;
   logic                 w_msr_we;
   logic                 w_alu_we;
   logic [DEPTH_W-1:0]   w_depth;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_ovf;
   logic                 w_unf;
   err_cause_t           w_err_cause;
   logic                 r_err;

   always_comb begin
      w_alu         = '0;
      w_alu[FLAG_N] = bus.dataInN;
      w_alu[FLAG_Z] = bus.dataInZ;
      w_alu[FLAG_C] = bus.dataInC;
      w_alu[FLAG_V] = bus.dataInV;
   end

   // Save and restore together cancel each other and are flagged as illegal.
   assign w_active   = ~bus.controlInStall;
   assign w_save_req = w_active & bus.controlInIrqSave & ~bus.controlInIrqRestore;
   assign w_rest_req = w_active & bus.controlInIrqRestore & ~bus.controlInIrqSave;
   assign w_illegal  = w_active & bus.controlInIrqSave & bus.controlInIrqRestore;
   assign w_pop_ok   = w_rest_req & ~w_empty;
   assign w_msr_we   = bus.controlInMsrWrite & ~bus.controlInFlush;
   assign w_alu_we   = bus.controlInSetFlags & bus.controlInCondMet & ~bus.controlInFlush;

   always_comb begin
      w_flags_nxt = r_flags;
      if (w_active) begin
         if (w_pop_ok)
            w_flags_nxt = w_top;
         else if (w_msr_we)
            w_flags_nxt = bus.dataInMsr;
         else if (w_alu_we)
            w_flags_nxt = (r_flags & ~bus.dataInMask) | (w_alu & bus.dataInMask);
      end
   end

   // Push the post-update value so an instruction retiring on interrupt entry is kept.
   flag_shadow_stack #(
      .DEPTH (SHADOW_DEPTH)
   ) u_stack (
      .clk           (clk),
      .rst           (rst),
      .i_push        (w_save_req),
      .i_pop         (w_rest_req),
      .i_data        (w_flags_nxt),
      .o_top_c       (w_top),
      .o_depth       (w_depth),
      .o_full        (w_full),
      .o_empty       (w_empty),
      .o_overflow_c  (w_ovf),
      .o_underflow_c (w_unf)
   );

   always_comb begin
      w_err_cause = ERR_NONE;
      if (w_illegal)
         w_err_cause = ERR_ILLEGAL;
      else if (w_ovf)
         w_err_cause = ERR_OVERFLOW;
      else if (w_unf)
         w_err_cause = ERR_UNDERFLOW;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flags <= FLAG_RESET;
         r_err   <= 1'b0;
      end else begin
         r_flags <= w_flags_nxt;
         if (w_active) begin
            if (w_err_cause != ERR_NONE)
               r_err <= 1'b1;
            else if (bus.controlInErrClr)
               r_err <= 1'b0;
         end
      end
   end

`ifdef FLAG_BYPASS_EN
   assign bus.dataOutN = w_flags_nxt[FLAG_N];
   assign bus.dataOutZ = w_flags_nxt[FLAG_Z];
   assign bus.dataOutC = w_flags_nxt[FLAG_C];
   assign bus.dataOutV = w_flags_nxt[FLAG_V];
`else
   assign bus.dataOutN = r_flags[FLAG_N];
   assign bus.dataOutZ = r_flags[FLAG_Z];
   assign bus.dataOutC = r_flags[FLAG_C];
   assign bus.dataOutV = r_flags[FLAG_V];
`endif

   assign bus.dataOutDepth      = w_depth;
   assign bus.dataOutStackFull  = w_full;
   assign bus.dataOutStackEmpty = w_empty;
   assign bus.dataOutStackErr   = r_err;

endmodule

// File: tb/tb_flag_register_unit.sv
// Bench for flag_register_unit: directed vector table, reset/bypass sequences, random vs queue model.
module tb_flag_register_unit;
   import flag_register_unit_pkg::*;

   localparam int unsigned DEPTH = 2;

   typedef struct {
      logic   stall, flush, set, cond;
      flags_t mask, alu;
      logic   msr_we;
      flags_t msr;
      logic   save, restore, clr;
   } stim_t;

   typedef struct {
      stim_t       s;
      flags_t      ef;
      int unsigned ed;
      logic        ee;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   flag_register_unit_if #(.SHADOW_DEPTH(DEPTH)) bus ();

   flag_register_unit #(
      .SHADOW_DEPTH (DEPTH),
      .FLAG_RESET   (4'b0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int     errors = 0;
   int     checks = 0;
   flags_t m_flags;
   flags_t m_stk[$];
   logic   m_err;
   vec_t   tbl[28];

   function automatic flags_t out4();
      return {bus.dataOutN, bus.dataOutZ, bus.dataOutC, bus.dataOutV};
   endfunction

   function automatic stim_t mk(input logic [3:0] ctl, input flags_t mask, input flags_t alu,
                                input logic msr_we, input flags_t msr, input logic [2:0] sr);
      stim_t s;
      {s.stall, s.flush, s.set, s.cond} = ctl;
      s.mask = mask; s.alu = alu; s.msr_we = msr_we; s.msr = msr;
      {s.save, s.restore, s.clr} = sr;
      return s;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input stim_t s);
      bus.controlInStall      = s.stall;
      bus.controlInFlush      = s.flush;
      bus.controlInSetFlags   = s.set;
      bus.controlInCondMet    = s.cond;
      bus.dataInMask          = s.mask;
      bus.dataInN             = s.alu[3];
      bus.dataInZ             = s.alu[2];
      bus.dataInC             = s.alu[1];
      bus.dataInV             = s.alu[0];
      bus.controlInMsrWrite   = s.msr_we;
      bus.dataInMsr           = s.msr;
      bus.controlInIrqSave    = s.save;
      bus.controlInIrqRestore = s.restore;
      bus.controlInErrClr     = s.clr;
   endtask

   // Reference: flags as a 4-bit value, shadow stack as a queue.
   task automatic model_step(input stim_t s);
      flags_t f;
      logic   popped;
      logic   nerr;
      if (!s.stall) begin
         f = m_flags; popped = 1'b0; nerr = 1'b0;
         if (s.restore && !s.save && m_stk.size() > 0) begin
            f = m_stk.pop_back();
            popped = 1'b1;
         end
         if (!popped && !s.flush) begin
            if (s.msr_we) f = s.msr;
            else if (s.set && s.cond)
               for (int i = 0; i < 4; i++) if (s.mask[i]) f[i] = s.alu[i];
         end
         if (s.save && s.restore) nerr = 1'b1;
         else if (s.save) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(f);
            else nerr = 1'b1;
         end else if (s.restore && !popped) nerr = 1'b1;
         m_err   = nerr ? 1'b1 : (s.clr ? 1'b0 : m_err);
         m_flags = f;
      end
   endtask

   task automatic step(input stim_t s);
      drive(s);
      model_step(s);
      @(posedge clk);
      #1;
      drive(mk(4'b0, 4'h0, 4'h0, 1'b0, 4'h0, 3'b0));
   endtask

   task automatic check_model(input string tag);
      check({tag, ".flags"}, 32'(out4()), 32'(m_flags));
      check({tag, ".depth"}, 32'(bus.dataOutDepth), 32'(m_stk.size()));
      check({tag, ".full"},  32'(bus.dataOutStackFull),  32'(m_stk.size() == DEPTH));
      check({tag, ".empty"}, 32'(bus.dataOutStackEmpty), 32'(m_stk.size() == 0));
      check({tag, ".err"},   32'(bus.dataOutStackErr),   32'(m_err));
   endtask

   task automatic model_reset();
      m_flags = 4'b0000;
      m_stk.delete();
      m_err = 1'b0;
   endtask

   initial begin
      stim_t s;
      flags_t exp_now;

      tbl[0]  = '{mk(4'b0011, 4'hF, 4'b1010, 0, 4'h0, 3'b000), 4'b1010, 0, 0};
      tbl[1]  = '{mk(4'b0010, 4'hF, 4'b0101, 0, 4'h0, 3'b000), 4'b1010, 0, 0};
      tbl[2]  = '{mk(4'b0000, 4'h0, 4'h0,    1, 4'hF, 3'b000), 4'b1111, 0, 0};
      tbl[3]  = '{mk(4'b0011, 4'hC, 4'b0000, 0, 4'h0, 3'b000), 4'b0011, 0, 0};
      tbl[4]  = '{mk(4'b0000, 4'h0, 4'h0,    1, 4'hF, 3'b000), 4'b1111, 0, 0};
      tbl[5]  = '{mk(4'b0111, 4'hC, 4'b0000, 0, 4'h0, 3'b000), 4'b1111, 0, 0};
      tbl[6]  = '{mk(4'b0000, 4'h0, 4'h0,    1, 4'h6, 3'b000), 4'b0110, 0, 0};
      tbl[7]  = '{mk(4'b0011, 4'hF, 4'b1001, 0, 4'h0, 3'b100), 4'b1001, 1, 0};
      tbl[8]  = '{mk(4'b0000, 4'h0, 4'h0,    1, 4'h0, 3'b000), 4'b0000, 1, 0};
      tbl[9]  = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b010), 4'b1001, 0, 0};
      tbl[10] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b100), 4'b1001, 1, 0};
      tbl[11] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b100), 4'b1001, 2, 0};
      tbl[12] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b100), 4'b1001, 2, 1};
      tbl[13] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b001), 4'b1001, 2, 0};
      tbl[14] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b010), 4'b1001, 1, 0};
      tbl[15] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b010), 4'b1001, 0, 0};
      tbl[16] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b010), 4'b1001, 0, 1};
      tbl[17] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b001), 4'b1001, 0, 0};
      tbl[18] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b100), 4'b1001, 1, 0};
      tbl[19] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b110), 4'b1001, 1, 1};
      tbl[20] = '{mk(4'b1111, 4'hF, 4'b0000, 1, 4'h0, 3'b111), 4'b1001, 1, 1};
      tbl[21] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b001), 4'b1001, 1, 0};
      tbl[22] = '{mk(4'b0000, 4'h0, 4'h0,    1, 4'h5, 3'b000), 4'b0101, 1, 0};
      tbl[23] = '{mk(4'b0100, 4'h0, 4'h0,    1, 4'h3, 3'b000), 4'b0101, 1, 0};
      tbl[24] = '{mk(4'b0011, 4'hF, 4'b0000, 1, 4'h2, 3'b010), 4'b1001, 0, 0};
      tbl[25] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b011), 4'b1001, 0, 1};
      tbl[26] = '{mk(4'b0000, 4'h0, 4'h0,    0, 4'h0, 3'b001), 4'b1001, 0, 0};
      tbl[27] = '{mk(4'b0011, 4'hF, 4'b0000, 1, 4'hA, 3'b000), 4'b1010, 0, 0};

      rst = 1'b1;
      drive(mk(4'b0, 4'h0, 4'h0, 1'b0, 4'h0, 3'b0));
      model_reset();
      #12 rst = 1'b0;
      #1;
      check("reset.flags", 32'(out4()), 32'h0);
      check("reset.depth", 32'(bus.dataOutDepth), 32'd0);
      check("reset.empty", 32'(bus.dataOutStackEmpty), 32'd1);
      check("reset.full",  32'(bus.dataOutStackFull), 32'd0);
      check("reset.err",   32'(bus.dataOutStackErr), 32'd0);

      for (int i = 0; i < 28; i++) begin
         step(tbl[i].s);
         check($sformatf("vec%0d.flags", i), 32'(out4()), 32'(tbl[i].ef));
         check($sformatf("vec%0d.depth", i), 32'(bus.dataOutDepth), 32'(tbl[i].ed));
         check($sformatf("vec%0d.full", i),  32'(bus.dataOutStackFull),  32'(tbl[i].ed == DEPTH));
         check($sformatf("vec%0d.empty", i), 32'(bus.dataOutStackEmpty), 32'(tbl[i].ed == 0));
         check($sformatf("vec%0d.err", i),   32'(bus.dataOutStackErr),   32'(tbl[i].ee));
      end

      // Async reset in the middle of a cycle with a loaded stack.
      step(mk(4'b0, 4'h0, 4'h0, 0, 4'h0, 3'b100));
      step(mk(4'b0, 4'h0, 4'h0, 0, 4'h0, 3'b100));
      check_model("prerst");
      #2 rst = 1'b1;
      #1;
      check("midrst.flags", 32'(out4()), 32'h0);
      check("midrst.depth", 32'(bus.dataOutDepth), 32'd0);
      check("midrst.empty", 32'(bus.dataOutStackEmpty), 32'd1);
      check("midrst.full",  32'(bus.dataOutStackFull), 32'd0);
      #2 rst = 1'b0;
      model_reset();

      // Visibility of an ALU write before and after the committing edge.
      s = mk(4'b0011, 4'hF, 4'b0100, 0, 4'h0, 3'b000);
      drive(s);
      #1;
`ifdef FLAG_BYPASS_EN
      exp_now = 4'b0100;
`else
      exp_now = 4'b0000;
`endif
      check("bypass.same_cycle", 32'(out4()), 32'(exp_now));
      model_step(s);
      @(posedge clk);
      #1;
      drive(mk(4'b0, 4'h0, 4'h0, 1'b0, 4'h0, 3'b0));
      check("bypass.next_cycle", 32'(out4()), 32'h4);

      for (int n = 0; n < 600; n++) begin
         s.stall   = ($urandom_range(9) == 0);
         s.flush   = ($urandom_range(5) == 0);
         s.set     = $urandom_range(1) == 1;
         s.cond    = ($urandom_range(3) != 0);
         s.mask    = 4'($urandom);
         s.alu     = 4'($urandom);
         s.msr_we  = ($urandom_range(5) == 0);
         s.msr     = 4'($urandom);
         s.save    = ($urandom_range(4) == 0);
         s.restore = ($urandom_range(4) == 0);
         s.clr     = ($urandom_range(7) == 0);
         step(s);
         check_model($sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
